// File: rtl/disp_scan_pkg.sv
// disp_scan_pkg: shared state encoding and digit-selection helpers for the display scan controller
package disp_scan_pkg;
  localparam int NDIG = 3;
  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;
  function automatic logic [1:0] next_dig(input logic [1:0] a, input logic [NDIG-1:0] en);
    logic [1:0] r;
    logic [1:0] i;
    logic found;
    r = a;
    i = a;
    found = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      i = (i == 2'd2) ? 2'd0 : i + 2'd1;
      if (!found && (en & (3'b001 << i)) != 3'b000) begin
        r = i;
        found = 1'b1;
      end
    end
    return r;
  endfunction
  function automatic logic [NDIG-1:0] an_code(input logic [1:0] a);
    return ~(3'b001 << a);
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: ce-qualified counter that pulses tc and wraps when it reaches the compare value
module scan_prescaler #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ce,
  input  logic [CW-1:0] cmp,
  output logic          tc
);
  logic [CW-1:0] cnt;
  assign tc = ce && (cnt == cmp);
  // count enabled cycles, restarting on clear or terminal count
  always_ff @(posedge clk)
    if (clr || tc) cnt <= '0;
    else if (ce) cnt <= cnt + CW'(1);
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scans enabled digits of a 3-digit display with a blanking gap between digits
module disp_scan_ctrl
  import disp_scan_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 2,
  parameter int CW        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [2:0] dig_en,
  output logic [1:0] adr,
  output logic [2:0] an,
  output logic       step
);
  localparam logic [CW-1:0] SHOW_TC  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_CYC == 0 ? 0 : BLANK_CYC - 1);
  state_t state, ns;
  logic tc, adv;
  logic [1:0] na;
  scan_prescaler #(.CW(CW)) u_pre (
    .clk(clk),
    .clr(rst),
    .ce (ce),
    .cmp(state == SHOW ? SHOW_TC : BLANK_TC),
    .tc (tc)
  );
  // slot-end decisions: leave SHOW for BLANK, or move to the next enabled digit
  always_comb begin
    adv = tc && (state == BLANK || BLANK_CYC == 0);
    ns  = tc ? ((state == SHOW && BLANK_CYC != 0) ? BLANK : SHOW) : state;
    na  = adv ? next_dig(adr, dig_en) : adr;
  end
  // state, address and anodes all load from next-state values so they stay aligned
  always_ff @(posedge clk)
    if (rst) begin
      state <= SHOW;
      adr   <= 2'd0;
      an    <= 3'b111;
      step  <= 1'b0;
    end else if (ce) begin
      state <= ns;
      adr   <= na;
      step  <= adv && (dig_en != 3'b000);
      an    <= (ns == BLANK) ? 3'b111 : (an_code(na) | ~dig_en);
    end else begin
      step  <= 1'b0;
    end
  // address 3 and multiple lit anodes are unreachable
  always_ff @(posedge clk)
    if (!rst) assert (adr != 2'd3 && $countones(~an) <= 1);
endmodule
